// File: rtl/noc_link_pipe.sv
// Retimed multi-channel link: LAT forward {valid,data} stages, a receive FIFO per
// channel and LAT backward credit stages. The credit threshold covers the full round trip.
module noc_link_pipe #(
  parameter int FLIT_W = 16,
  parameter int NUM_CH = 1,
  parameter int LAT    = 2,
  parameter int DEPTH  = 2*LAT+2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_tx,
  input  logic [NUM_CH*FLIT_W-1:0] i_data,
  output logic [NUM_CH-1:0]        o_credit,
  output logic [NUM_CH-1:0]        o_tx,
  output logic [NUM_CH*FLIT_W-1:0] o_data,
  input  logic [NUM_CH-1:0]        i_credit,
  output logic [NUM_CH-1:0]        o_ovf
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  if (LAT < 1) begin : g_bad_lat
    $error("noc_link_pipe: LAT must be >= 1");
  end
  if (DEPTH < 2*LAT+2) begin : g_bad_depth
    $error("noc_link_pipe: DEPTH must be >= 2*LAT+2");
  end

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LAT-1:0]             fwd_v;
    logic [LAT-1:0][FLIT_W-1:0] fwd_d;
    logic [LAT-1:0]             bwd_c;
    logic [FLIT_W-1:0]          mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       ovf;
    logic                       push;
    logic                       pop;
    logic                       push_ok;
    logic                       credit_raw;

    always_comb begin
      push       = fwd_v[LAT-1];
      pop        = (count != '0) & i_credit[c];
      push_ok    = push & ((count < CNT_W'(DEPTH)) | pop);
      credit_raw = (DEPTH - int'(count)) >= 2*LAT+1;
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        fwd_v  <= '0;
        bwd_c  <= '0;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        fwd_v[0] <= i_tx[c];
        bwd_c[0] <= credit_raw;
        for (int i = 1; i < LAT; i++) begin
          fwd_v[i] <= fwd_v[i-1];
          bwd_c[i] <= bwd_c[i-1];
        end
        if (push_ok) wr_ptr <= ptr_next(wr_ptr);
        if (pop)     rd_ptr <= ptr_next(rd_ptr);
        if (push_ok && !pop)      count <= count + CNT_W'(1);
        else if (!push_ok && pop) count <= count - CNT_W'(1);
        if (push && !push_ok) ovf <= 1'b1;
      end
    end

    // Data path carries no reset; validity is tracked by fwd_v and count.
    always_ff @(posedge i_clk) begin
      if (i_tx[c]) fwd_d[0] <= i_data[c*FLIT_W +: FLIT_W];
      for (int i = 1; i < LAT; i++) fwd_d[i] <= fwd_d[i-1];
      if (push_ok) mem[wr_ptr] <= fwd_d[LAT-1];
    end

    assign o_tx[c]                     = (count != '0);
    assign o_data[c*FLIT_W +: FLIT_W]  = mem[rd_ptr];
    assign o_credit[c]                 = bwd_c[LAT-1];
    assign o_ovf[c]                    = ovf;
  end

endmodule

// File: tb/tb_noc_link_pipe.sv
// Randomized scoreboard bench for noc_link_pipe (4 channels, LAT=2, DEPTH=6).
// A posedge predictor models occupancy/credit; a negedge monitor compares DUT outputs.
module tb_noc_link_pipe;
  localparam int FLIT_W = 16;
  localparam int NUM_CH = 4;
  localparam int LAT    = 2;
  localparam int DEPTH  = 6;

  logic                     clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic [NUM_CH-1:0]        i_tx = '0;
  logic [NUM_CH*FLIT_W-1:0] i_data = '0;
  logic [NUM_CH-1:0]        o_credit;
  logic [NUM_CH-1:0]        o_tx;
  logic [NUM_CH*FLIT_W-1:0] o_data;
  logic [NUM_CH-1:0]        i_credit = '1;
  logic [NUM_CH-1:0]        o_ovf;

  noc_link_pipe #(.FLIT_W(FLIT_W), .NUM_CH(NUM_CH), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_tx(i_tx), .i_data(i_data), .o_credit(o_credit),
    .o_tx(o_tx), .o_data(o_data), .i_credit(i_credit), .o_ovf(o_ovf));

  always #5 clk = ~clk;

  typedef struct { logic [FLIT_W-1:0] d; int e; } sent_t;

  sent_t             sent_q [NUM_CH][$];
  logic [FLIT_W-1:0] sb_q   [NUM_CH][$];
  bit                cred_q [NUM_CH][$];
  int                mcnt    [NUM_CH];
  bit                exp_ovf [NUM_CH];
  int                xfer_cnt[NUM_CH];
  int                edge_n = 0;
  bit                mon_en = 1'b0;
  int                compared = 0;
  int                mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: flits land in the FIFO LAT edges after being sampled.
  always @(posedge clk) begin
    edge_n++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_rst) begin
        mcnt[c] = 0;
        exp_ovf[c] = 1'b0;
        sent_q[c].delete();
        sb_q[c].delete();
        cred_q[c].delete();
        for (int k = 0; k < LAT; k++) cred_q[c].push_back(1'b0);
      end else begin
        bit pop, raw;
        sent_t s;
        pop = (mcnt[c] != 0) && i_credit[c];
        raw = (DEPTH - mcnt[c]) >= 2*LAT+1;
        if (sent_q[c].size() > 0 && sent_q[c][0].e == edge_n - LAT) begin
          s = sent_q[c].pop_front();
          if (mcnt[c] < DEPTH || pop) begin
            sb_q[c].push_back(s.d);
            mcnt[c]++;
          end else begin
            exp_ovf[c] = 1'b1;
          end
        end
        if (pop) mcnt[c]--;
        if (i_tx[c]) begin
          s.d = i_data[c*FLIT_W +: FLIT_W];
          s.e = edge_n;
          sent_q[c].push_back(s);
        end
        cred_q[c].push_back(raw);
        void'(cred_q[c].pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        chk($sformatf("o_tx[%0d]", c), 32'(o_tx[c]), 32'(mcnt[c] != 0));
        chk($sformatf("o_credit[%0d]", c), 32'(o_credit[c]), 32'(cred_q[c][0]));
        chk($sformatf("o_ovf[%0d]", c), 32'(o_ovf[c]), 32'(exp_ovf[c]));
        if (o_tx[c] && i_credit[c]) begin
          xfer_cnt[c]++;
          if (sb_q[c].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL data[%0d]: got 0x%0h expected no flit", c, o_data[c*FLIT_W +: FLIT_W]);
          end else begin
            chk($sformatf("data[%0d]", c), 32'(o_data[c*FLIT_W +: FLIT_W]), 32'(sb_q[c].pop_front()));
          end
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int first;
    int seq;
    bit saw_low;
    bit held;

    for (int c = 0; c < NUM_CH; c++) xfer_cnt[c] = 0;

    // Reset held 3 cycles, then credit must appear exactly LAT cycles after release
    cyc(1);
    mon_en = 1'b1;
    cyc(2);
    i_rst = 1'b0;
    first = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_credit[0] && first < 0) first = k;
    end
    chk("credit_after_reset", 32'(first), 32'(LAT));
    cyc(1);

    // Single-flit latency: o_tx at cycle t+LAT+1
    i_credit = '1;
    i_tx[0] = 1'b1;
    i_data[0 +: FLIT_W] = 16'hA5A5;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_tx[0] && first < 0) begin
        first = k;
        chk("latency_data", 32'(o_data[0 +: FLIT_W]), 32'h0000_A5A5);
      end
      if (k == 0) begin
        @(posedge clk);
        #1;
        i_tx[0] = 1'b0;
      end
    end
    chk("latency_cycles", 32'(first), 32'(LAT+1));

    // Back-pressure: credit-respecting upstream, downstream stalled
    i_credit = '0;
    seq = 0;
    saw_low = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!o_credit[0]) saw_low = 1'b1;
      i_tx = o_credit;
      for (int c = 0; c < NUM_CH; c++) i_data[c*FLIT_W +: FLIT_W] = {4'(c), 12'(seq)};
      seq++;
      cyc(1);
    end
    i_tx = '0;
    chk("credit_fell", 32'(saw_low), 32'd1);
    cyc(4);
    chk("bp_fifo_full", 32'(o_tx), 32'hF);
    i_credit = '1;
    cyc(20);

    // Stream 100 back-to-back flits on every channel
    held = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (o_credit != '1) held = 1'b0;
      i_tx = '1;
      for (int c = 0; c < NUM_CH; c++) i_data[c*FLIT_W +: FLIT_W] = 16'($urandom);
      cyc(1);
    end
    i_tx = '0;
    chk("credit_held_stream", 32'(held), 32'd1);
    cyc(6);

    // Overflow on ch1: ignore credit while stalled
    i_credit = '0;
    for (int k = 0; k < 12; k++) begin
      i_tx = 4'b0010;
      i_data[FLIT_W +: FLIT_W] = 16'h1100 + 16'(k);
      cyc(1);
    end
    i_tx = '0;
    cyc(4);
    chk("ovf_set", 32'(o_ovf[1]), 32'd1);
    xfer_cnt[1] = 0;
    i_credit = '1;
    cyc(15);
    chk("ovf_drain_count", 32'(xfer_cnt[1]), 32'(DEPTH));
    chk("ovf_sticky", 32'(o_ovf[1]), 32'd1);

    // Multi-channel random traffic with ch2 stalled, then mid-stream reset
    xfer_cnt[2] = 0;
    for (int k = 0; k < 150; k++) begin
      i_credit = 4'($urandom) & 4'b1011;
      i_tx = o_credit & 4'($urandom);
      for (int c = 0; c < NUM_CH; c++) i_data[c*FLIT_W +: FLIT_W] = 16'($urandom);
      cyc(1);
    end
    chk("ch2_stalled", 32'(xfer_cnt[2]), 32'd0);
    i_rst = 1'b1;
    cyc(1);
    i_rst = 1'b0;
    @(negedge clk);
    chk("reset_empty_o_tx", 32'(o_tx), 32'd0);
    chk("reset_ovf_clear", 32'(o_ovf), 32'd0);
    cyc(1);
    for (int k = 0; k < 100; k++) begin
      i_credit = 4'($urandom);
      i_tx = o_credit & 4'($urandom);
      for (int c = 0; c < NUM_CH; c++) i_data[c*FLIT_W +: FLIT_W] = 16'($urandom);
      cyc(1);
    end
    i_tx = '0;
    i_credit = '1;
    cyc(30);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("drained[%0d]", c), 32'(sb_q[c].size()), 32'd0);
      chk($sformatf("empty_end[%0d]", c), 32'(o_tx[c]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
